// File: rtl/fwd_ctrl_unit_if.sv
// fwd_ctrl_unit_if
// Bundles the ID-stage request signals and the forwarding/stall responses
// of the forwarding controller.
//   rs, rt            : ID source register numbers
//   use_rs, use_rt    : ID instruction actually reads rs / rt
//   id_valid          : ID holds a real instruction (0 = bubble)
//   id_wreg, id_m2reg : ID instruction writes the register file / is a load
//   id_dest           : ID instruction destination register
//   fwda, fwdb        : operand A/B forward selects (00 qa, 01 r, 10 mr, 11 mdo)
//   stall             : freeze PC and IF/ID, bubble into EXE
//   stall_count       : saturating count of stall cycles
// The controller connects through the slave modport, the pipeline side
// (or a testbench) through the master modport.
`timescale 1ns/1ps
interface fwd_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             use_rs;
    logic             use_rt;
    logic             id_valid;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_dest;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs, rt, use_rs, use_rt, id_valid, id_wreg, id_m2reg, id_dest,
        input  fwda, fwdb, stall, stall_count
    );

    modport slave (
        input  rs, rt, use_rs, use_rt, id_valid, id_wreg, id_m2reg, id_dest,
        output fwda, fwdb, stall, stall_count
    );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps shadow copies of the write-back attributes of the instructions in
// EXE and MEM, derives the ID-stage forward selects from them, and raises
// stall for one cycle when ID consumes the result of a load still in EXE.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fwd_ctrl_unit_if slave modport (ID request in, selects/stall out)
`timescale 1ns/1ps
module fwd_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_ctrl_unit_if.slave     bus
);

    logic             e_wreg_q,  e_wreg_d;
    logic             e_m2reg_q, e_m2reg_d;
    logic [4:0]       e_dest_q,  e_dest_d;
    logic             m_wreg_q,  m_wreg_d;
    logic             m_m2reg_q, m_m2reg_d;
    logic [4:0]       m_dest_q,  m_dest_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic eA, eB, mA, mB;
    logic stall;
    logic [1:0] fwda, fwdb;

    // Match each ID source against the EXE and MEM writers. Register $0 is
    // hard-wired to zero in the register file, so it never matches.
    always_comb begin
        eA = bus.use_rs & e_wreg_q & (e_dest_q == bus.rs) & (bus.rs != 5'd0);
        mA = bus.use_rs & m_wreg_q & (m_dest_q == bus.rs) & (bus.rs != 5'd0);
        eB = bus.use_rt & e_wreg_q & (e_dest_q == bus.rt) & (bus.rt != 5'd0);
        mB = bus.use_rt & m_wreg_q & (m_dest_q == bus.rt) & (bus.rt != 5'd0);
    end

    // Select priority: the younger EXE ALU result wins. A load in EXE has no
    // data yet, so it falls through to the MEM rules and is covered by the
    // stall instead; after the bubble it sits in MEM and selects mdo.
    always_comb begin
        fwda = 2'b00;
        if (eA && !e_m2reg_q)      fwda = 2'b01;
        else if (mA && m_m2reg_q)  fwda = 2'b11;
        else if (mA)               fwda = 2'b10;

        fwdb = 2'b00;
        if (eB && !e_m2reg_q)      fwdb = 2'b01;
        else if (mB && m_m2reg_q)  fwdb = 2'b11;
        else if (mB)               fwdb = 2'b10;
    end

    // One stall covers both operands; the bubble that follows removes the
    // load from EXE, so the condition cannot hold two cycles in a row.
    assign stall = bus.id_valid & e_m2reg_q & (eA | eB);

    assign bus.fwda        = fwda;
    assign bus.fwdb        = fwdb;
    assign bus.stall       = stall;
    assign bus.stall_count = stall_count_q;

    // Next-state for the shadow pipeline and the stall counter. MEM always
    // advances; EXE takes a bubble while stalled. The counter saturates.
    always_comb begin
        m_wreg_d  = e_wreg_q;
        m_m2reg_d = e_m2reg_q;
        m_dest_d  = e_dest_q;
        if (stall) begin
            e_wreg_d  = 1'b0;
            e_m2reg_d = 1'b0;
            e_dest_d  = 5'd0;
        end else begin
            e_wreg_d  = bus.id_valid & bus.id_wreg;
            e_m2reg_d = bus.id_valid & bus.id_m2reg;
            e_dest_d  = bus.id_dest;
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    // State registers; reset empties both slots so nothing can forward or
    // stall until real instructions flow in again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_wreg_q      <= 1'b0;
            e_m2reg_q     <= 1'b0;
            e_dest_q      <= 5'd0;
            m_wreg_q      <= 1'b0;
            m_m2reg_q     <= 1'b0;
            m_dest_q      <= 5'd0;
            stall_count_q <= '0;
        end else begin
            e_wreg_q      <= e_wreg_d;
            e_m2reg_q     <= e_m2reg_d;
            e_dest_q      <= e_dest_d;
            m_wreg_q      <= m_wreg_d;
            m_m2reg_q     <= m_m2reg_d;
            m_dest_q      <= m_dest_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb_fwd_ctrl_unit
// Directed testbench for fwd_ctrl_unit: one instance with the default
// 16-bit counter and one with a 3-bit counter for saturation.
`timescale 1ns/1ps
module tb_fwd_ctrl_unit;

    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;

    fwd_ctrl_unit_if #(.CNT_W(16)) mainBus ();
    fwd_ctrl_unit_if #(.CNT_W(3))  satBus  ();

    fwd_ctrl_unit #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mainBus.slave)
    );

    fwd_ctrl_unit #(.CNT_W(3)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (satBus.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one ID-stage instruction onto the main instance.
    task automatic applyStimulus(input logic valid, input logic wreg,
                                 input logic m2reg, input logic [4:0] dest,
                                 input logic [4:0] rsV, input logic [4:0] rtV,
                                 input logic urs, input logic urt);
        mainBus.id_valid = valid;
        mainBus.id_wreg  = wreg;
        mainBus.id_m2reg = m2reg;
        mainBus.id_dest  = dest;
        mainBus.rs       = rsV;
        mainBus.rt       = rtV;
        mainBus.use_rs   = urs;
        mainBus.use_rt   = urt;
    endtask

    // Drive one ID-stage instruction onto the saturation instance.
    task automatic applySat(input logic valid, input logic m2reg,
                            input logic [4:0] dest, input logic [4:0] rsV,
                            input logic urs);
        satBus.id_valid = valid;
        satBus.id_wreg  = m2reg;
        satBus.id_m2reg = m2reg;
        satBus.id_dest  = dest;
        satBus.rs       = rsV;
        satBus.rt       = 5'd0;
        satBus.use_rs   = urs;
        satBus.use_rt   = 1'b0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic [1:0] fa,
                             input logic [1:0] fb, input logic st);
        checkOutput({tag, ".fwda"},  {30'd0, mainBus.fwda}, {30'd0, fa});
        checkOutput({tag, ".fwdb"},  {30'd0, mainBus.fwdb}, {30'd0, fb});
        checkOutput({tag, ".stall"}, {31'd0, mainBus.stall}, {31'd0, st});
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        applySat(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

        // Reset held: a would-be writer and readers of $5 see nothing.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
        #2;
        checkMain("rstHold0", 2'b00, 2'b00, 1'b0);
        tick();
        tick();
        checkMain("rstHold2", 2'b00, 2'b00, 1'b0);
        checkOutput("rstCount", 32'(mainBus.stall_count), 32'd0);

        // Release with no writers; selects stay 00.
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1);
        tick();
        tick();
        #1;
        checkMain("idleRead", 2'b00, 2'b00, 1'b0);

        // ALU chain on $3: EXE forward, then MEM forward, then none.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0);
        #1;
        checkMain("aluExe", 2'b01, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
        #1;
        checkMain("aluMem", 2'b00, 2'b10, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 1'b1, 1'b1);
        #1;
        checkMain("aluGone", 2'b00, 2'b00, 1'b0);

        // Load-use on $4 with both operands: one stall, then mdo.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 1'b1);
        #1;
        checkMain("luStall", 2'b00, 2'b00, 1'b1);
        tick();
        checkMain("luAfter", 2'b11, 2'b11, 1'b0);
        checkOutput("luCount", 32'(mainBus.stall_count), 32'd1);

        // Priority: $2 written in both MEM and EXE by ALU ops.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 5'd2, 1'b1, 1'b1);
        #1;
        checkMain("prioBoth", 2'b01, 2'b01, 1'b0);
        checkOutput("prioCount", 32'(mainBus.stall_count), 32'd1);

        // Writer to $0 in EXE, second $2 writer in MEM.
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
        #1;
        checkMain("zeroReg", 2'b00, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1);
        #1;
        checkMain("zeroNoUse", 2'b00, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd2, 1'b0, 1'b0);
        #1;
        checkMain("noUse", 2'b00, 2'b00, 1'b0);

        // Load in EXE seen by a bubble: no stall, selects still evaluated.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0);
        #1;
        checkMain("bubbleLoad", 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0);
        #1;
        checkMain("bubbleMem", 2'b11, 2'b00, 1'b0);
        checkOutput("bubbleCount", 32'(mainBus.stall_count), 32'd1);

        // Back-to-back loads to $8: consumer stalls once on the younger one.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checkMain("b2bSecond", 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0);
        #1;
        checkMain("b2bStall", 2'b11, 2'b00, 1'b1);
        tick();
        checkMain("b2bAfter", 2'b11, 2'b00, 1'b0);
        checkOutput("b2bCount", 32'(mainBus.stall_count), 32'd2);

        // Reset pulse in the middle of a load-use stall on $7.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
        #1;
        checkMain("midStall", 2'b00, 2'b00, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midRstStall", {31'd0, mainBus.stall}, 32'd0);
        checkOutput("midRstCount", 32'(mainBus.stall_count), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkMain("midRelease", 2'b00, 2'b00, 1'b0);
        tick();
        checkMain("midNextCycle", 2'b00, 2'b00, 1'b0);
        checkOutput("midCountAfter", 32'(mainBus.stall_count), 32'd0);

        // Saturation on the 3-bit counter: ten load/consumer pairs.
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            applySat(1'b1, 1'b1, 5'd9, 5'd0, 1'b0);
            tick();
            applySat(1'b1, 1'b0, 5'd0, 5'd9, 1'b1);
            #1;
            checkOutput($sformatf("satStall%0d", i), {31'd0, satBus.stall}, 32'd1);
            tick();
            checkOutput($sformatf("satCount%0d", i), 32'(satBus.stall_count),
                        (i < 7) ? 32'(i) : 32'd7);
            applySat(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
